// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - instruction prefetch queue with credit-based fetch issue
//
// Fetches instruction bytes ahead of the IR1 stage into a DEPTH-entry circular
// buffer. A fetch is only issued when the buffer is guaranteed to have space
// for the byte when it returns, one cycle later.
//
// Ports:
//   clock        single clock, rising edge
//   reset        synchronous active-high reset
//   enable       1 = issue fetches, 0 = stop issuing
//   mem_rd       fetch request to the instruction read port
//   mem_addr     fetch address (current fetch pc)
//   mem_q        instruction byte, valid the cycle after mem_rd
//   deq_valid    head entry valid
//   deq_ready    consumer accepts head entry this cycle
//   deq_instr    head instruction byte
//   deq_pc       address the head instruction was fetched from
//   redirect     taken branch/jump: flush queue and refetch
//   redirect_pc  new fetch address when redirect=1
//   count        number of valid entries, 0..DEPTH
module instr_prefetch_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic       mem_rd,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_q,
    output logic       deq_valid,
    input  logic       deq_ready,
    output logic [7:0] deq_instr,
    output logic [7:0] deq_pc,
    input  logic       redirect,
    input  logic [7:0] redirect_pc,
    output logic [3:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    fpc;
    logic          infl;
    logic [7:0]    infl_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [7:0]    instr_mem [DEPTH];
    logic [7:0]    pc_mem    [DEPTH];

    logic [4:0]    occupancy;
    logic          credit_ok;
    logic          enq;
    logic          deq;

    // Entries already held plus the byte still on its way back must leave room
    // for one more, so a returning byte can never find the buffer full.
    assign occupancy = {1'b0, count} + {4'b0000, infl};
    assign credit_ok = occupancy < 5'(DEPTH);

    assign mem_rd    = (state == RUN) && !redirect && !reset && credit_ok;
    assign mem_addr  = fpc;

    assign deq_valid = (count != 4'd0);
    assign deq_instr = instr_mem[rd_ptr];
    assign deq_pc    = pc_mem[rd_ptr];

    assign enq = infl && !redirect;
    assign deq = deq_valid && deq_ready && !redirect;

    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = FLUSH;
        end else begin
            case (state)
                IDLE:    state_next = enable ? RUN : IDLE;
                RUN:     state_next = enable ? RUN : IDLE;
                FLUSH:   state_next = enable ? RUN : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fpc     <= RESET_PC;
            infl    <= 1'b0;
            infl_pc <= 8'h00;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= 8'h00;
                pc_mem[i]    <= 8'h00;
            end
        end else begin
            // mem_rd is forced low during redirect, so this also drops any
            // byte that would otherwise be captured next cycle.
            infl <= mem_rd;
            if (redirect) begin
                fpc    <= redirect_pc;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= 4'd0;
            end else begin
                if (mem_rd) begin
                    fpc     <= fpc + 8'd1;
                    infl_pc <= fpc;
                end
                if (enq) begin
                    instr_mem[wr_ptr] <= mem_q;
                    pc_mem[wr_ptr]    <= infl_pc;
                    wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                end
                if (deq) begin
                    rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                end
                case ({enq, deq})
                    2'b10:   count <= count + 4'd1;
                    2'b01:   count <= count - 4'd1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - scoreboard testbench for instr_prefetch_queue
module tb_instr_prefetch_queue;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [7:0] mem_q;
    logic       deq_valid;
    logic       deq_ready;
    logic [7:0] deq_instr;
    logic [7:0] deq_pc;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic [3:0] count;

    int tests = 0;
    int fails = 0;
    logic mon_en = 1'b0;
    logic [15:0] exp_q [$];

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(8'h00)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_q       (mem_q),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_instr   (deq_instr),
        .deq_pc      (deq_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .count       (count)
    );

    always #5 clock = ~clock;

    // 1-cycle read memory, mem[a] = a ^ 5A; junk when no read was issued
    always @(posedge clock) begin
        mem_q <= mem_rd ? (mem_addr ^ 8'h5A) : 8'hEE;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted head entry is compared with the scoreboard
    always @(negedge clock) begin
        if (mon_en && !reset && !redirect && deq_valid && deq_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL deq_extra: got pc=%h instr=%h expected none", deq_pc, deq_instr);
            end else begin
                check("deq_pc_instr", {deq_pc, deq_instr}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push_seq(input logic [7:0] start, input int n);
        logic [7:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({a, a ^ 8'h5A});
            a = a + 8'd1;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            tick();
            k++;
        end
        mon_en = 1'b0;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        mon_en      = 1'b0;
        reset       = 1'b1;
        enable      = 1'b0;
        deq_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; deq_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        tick();
        tick();

        // Reset state
        check("rst_count", 16'(count), 16'd0);
        check("rst_deq_valid", 16'(deq_valid), 16'd0);
        check("rst_mem_rd", 16'(mem_rd), 16'd0);
        check("rst_head", {deq_pc, deq_instr}, 16'h0000);
        check("rst_mem_addr", 16'(mem_addr), 16'h0000);
        reset = 1'b0;

        // Streaming from reset, latency of the first entry
        push_seq(8'h00, 8);
        mon_en = 1'b1; enable = 1'b1; deq_ready = 1'b1;
        tick();
        check("s1_mem_rd", 16'(mem_rd), 16'd1);
        check("s1_addr", 16'(mem_addr), 16'h0000);
        check("s1_valid_c1", 16'(deq_valid), 16'd0);
        tick();
        check("s1_valid_c2", 16'(deq_valid), 16'd0);
        tick();
        check("s1_valid_c3", 16'(deq_valid), 16'd1);
        drain();
        do_reset();

        // Fill without draining: count saturates, credit stops issue
        enable = 1'b1;
        repeat (10) tick();
        check("fill_count", 16'(count), 16'd4);
        check("fill_mem_rd", 16'(mem_rd), 16'd0);
        check("fill_fpc", 16'(mem_addr), 16'h0004);
        check("fill_head", {deq_pc, deq_instr}, 16'h005A);
        push_seq(8'h00, 9);
        mon_en = 1'b1; deq_ready = 1'b1;
        tick();
        check("resume_count", 16'(count), 16'd3);
        check("resume_mem_rd", 16'(mem_rd), 16'd1);
        check("resume_addr", 16'(mem_addr), 16'h0004);
        drain();
        do_reset();

        // Dequeue request on an empty queue
        deq_ready = 1'b1;
        tick();
        tick();
        check("empty_count", 16'(count), 16'd0);
        check("empty_valid", 16'(deq_valid), 16'd0);
        do_reset();

        // Redirect with a byte in flight
        enable = 1'b1;
        repeat (3) tick();
        check("pre_redir_count", 16'(count), 16'd1);
        redirect = 1'b1; redirect_pc = 8'h40;
        #1;
        check("redir_mem_rd", 16'(mem_rd), 16'd0);
        tick();
        redirect = 1'b0;
        check("redir_count", 16'(count), 16'd0);
        check("redir_valid", 16'(deq_valid), 16'd0);
        check("flush_mem_rd", 16'(mem_rd), 16'd0);
        check("flush_addr", 16'(mem_addr), 16'h0040);
        push_seq(8'h40, 6);
        mon_en = 1'b1; deq_ready = 1'b1;
        tick();
        check("post_flush_count", 16'(count), 16'd0);
        check("post_flush_mem_rd", 16'(mem_rd), 16'd1);
        drain();
        do_reset();

        // Fetch address wrap FF -> 00
        push_seq(8'hFE, 6);
        mon_en = 1'b1; enable = 1'b1; deq_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 8'hFE;
        tick();
        redirect = 1'b0;
        drain();
        do_reset();

        // Reset mid-operation with count=3 and a byte in flight
        enable = 1'b1;
        repeat (5) tick();
        check("mid_count", 16'(count), 16'd3);
        reset = 1'b1; redirect = 1'b1; redirect_pc = 8'h80;
        tick();
        check("mid_rst_count", 16'(count), 16'd0);
        check("mid_rst_valid", 16'(deq_valid), 16'd0);
        check("mid_rst_mem_rd", 16'(mem_rd), 16'd0);
        check("mid_rst_head", {deq_pc, deq_instr}, 16'h0000);
        reset = 1'b0; redirect = 1'b0; enable = 1'b0;
        tick();
        check("mid_rst_nostore", 16'(count), 16'd0);
        check("mid_rst_addr", 16'(mem_addr), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
